// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, SR/Cause field positions and
// exception codes used by the exception controller and its helpers.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_BD_BIT  = 31;
    localparam int EXCCODE_LSB   = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_irq_sense.sv
// Per-line interrupt sensing: level lines pass straight through, edge lines
// latch a pending bit on a 0->1 transition that software clears via Cause.
module cp0_irq_sense #(
    parameter int         NUM_IRQ       = 6,
    parameter logic [5:0] IRQ_EDGE_MASK = 6'b000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] hw_int,
    input  logic [NUM_IRQ-1:0] clr,
    output logic [NUM_IRQ-1:0] ip
);

    localparam logic [NUM_IRQ-1:0] EDGE = IRQ_EDGE_MASK[NUM_IRQ-1:0];

    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] rise;

    assign rise = hw_int & ~prev_q;

    // A rising edge wins over a same-cycle clear, so the pending bit survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= hw_int;
            pend_q <= ((pend_q & ~clr) | rise) & EDGE;
        end
    end

    assign ip = (EDGE & pend_q) | (~EDGE & hw_int);

endmodule

// File: rtl/cp0_exc_ctrl.sv
// MEM-stage coprocessor 0: SR/Cause/EPC/PRId, interrupt vs exception
// arbitration and flush request. Define CP0_TIMER_EN to build Count/Compare.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ       = 6,
    parameter logic [5:0]  IRQ_EDGE_MASK = 6'b000000,
    parameter logic [31:0] TEXT_BASE     = 32'h0000_3000,
    parameter logic [31:0] TEXT_END      = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE    = 32'h2000_0217
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] hw_int,
    input  logic [4:0]         exc_code,
    input  logic               exc_bd,
    input  logic               md_busy,
    input  logic [31:0]        exc_pc,
    input  logic               eret,
    input  logic               mtc0_we,
    input  logic [4:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [4:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               irq_take,
    output logic [31:0]        epc
);

    logic [31:0]        sr_q;
    logic [31:0]        epc_q;
    logic               cause_bd_q;
    logic [NUM_IRQ-1:0] cause_ip_q;
    logic [4:0]         cause_exc_q;
    logic [31:0]        cause_val;

    logic [NUM_IRQ-1:0] ip_sense;
    logic [NUM_IRQ-1:0] ip;
    logic [NUM_IRQ-1:0] ip_clr;
    logic [NUM_IRQ-1:0] im;
    logic               exl;
    logic               ie;

    logic               int_req;
    logic               exc_req;
    logic               do_mtc0;

    logic [31:0]        pc_al;
    logic               in_window;
    logic [31:0]        epc_int;
    logic [31:0]        epc_exc;

    assign exl = sr_q[SR_EXL_BIT];
    assign ie  = sr_q[SR_IE_BIT];
    assign im  = sr_q[SR_IM_LSB +: NUM_IRQ];

    assign int_req  = (|(ip & im)) & ie & ~exl;
    assign exc_req  = (exc_code != 5'd0) & ~exl;
    assign irq_take = int_req | exc_req;

    // MTC0 only lands when nothing of higher priority claims the cycle.
    assign do_mtc0 = mtc0_we & ~irq_take & ~eret;
    assign ip_clr  = (do_mtc0 && wr_addr == CP0_CAUSE) ? ~wr_data[CAUSE_IP_LSB +: NUM_IRQ]
                                                       : '0;

    cp0_irq_sense #(
        .NUM_IRQ       (NUM_IRQ),
        .IRQ_EDGE_MASK (IRQ_EDGE_MASK)
    ) u_irq_sense (
        .clk    (clk),
        .reset  (reset),
        .hw_int (hw_int),
        .clr    (ip_clr),
        .ip     (ip_sense)
    );

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        timer_pend_q;
    logic        cmp_wr;

    assign cmp_wr = do_mtc0 && (wr_addr == CP0_COMPARE);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            compare_q    <= '0;
            timer_pend_q <= 1'b0;
        end else if (cmp_wr) begin
            compare_q    <= wr_data;
            count_q      <= '0;
            timer_pend_q <= 1'b0;
        end else begin
            count_q <= count_q + 32'd1;
            if (count_q == compare_q && compare_q != 32'd0)
                timer_pend_q <= 1'b1;
        end
    end

    // The timer shares the top interrupt line with the external request.
    always_comb begin
        ip              = ip_sense;
        ip[NUM_IRQ-1]   = ip_sense[NUM_IRQ-1] | timer_pend_q;
    end
`else
    assign ip = ip_sense;
`endif

    assign pc_al     = word_align(exc_pc);
    assign in_window = (pc_al >= TEXT_BASE) && (pc_al < TEXT_END);

    // An interrupt on an instruction whose mult/div already launched must
    // resume after it, otherwise the operation would be issued twice.
    always_comb begin
        epc_int = pc_al;
        epc_exc = pc_al;
        if (exc_bd) begin
            epc_int = pc_al - 32'd4;
            epc_exc = pc_al - 32'd4;
        end else if (exc_code == 5'd0 && md_busy) begin
            epc_int = pc_al + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q        <= '0;
            epc_q       <= '0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
        end else begin
            cause_ip_q <= ip;
            if (int_req) begin
                sr_q[SR_EXL_BIT] <= 1'b1;
                cause_exc_q      <= EXC_INT;
                cause_bd_q       <= exc_bd;
                if (in_window)
                    epc_q <= epc_int;
            end else if (exc_req) begin
                sr_q[SR_EXL_BIT] <= 1'b1;
                cause_exc_q      <= exc_code;
                cause_bd_q       <= exc_bd;
                if (in_window)
                    epc_q <= epc_exc;
            end else if (eret) begin
                sr_q[SR_EXL_BIT] <= 1'b0;
            end else if (mtc0_we) begin
                case (wr_addr)
                    CP0_SR:  sr_q  <= wr_data;
                    CP0_EPC: epc_q <= word_align(wr_data);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cause_val                              = '0;
        cause_val[CAUSE_BD_BIT]                = cause_bd_q;
        cause_val[CAUSE_IP_LSB +: NUM_IRQ]     = cause_ip_q;
        cause_val[EXCCODE_LSB +: 5]            = cause_exc_q;
    end

    // Reads see pre-edge state; there is no bypass from a same-cycle MTC0.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CP0_SR:      rd_data = sr_q;
            CP0_CAUSE:   rd_data = cause_val;
            CP0_EPC:     rd_data = epc_q;
            CP0_PRID:    rd_data = PRID_VALUE;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rd_data = count_q;
            CP0_COMPARE: rd_data = compare_q;
`endif
            default:     rd_data = '0;
        endcase
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural CP0 model kept in the bench.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_int;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic        md_busy;
    logic [31:0] exc_pc;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        irq_take;
    logic [31:0] epc;

    int n_vec;
    int n_err;

    logic [64:0] exp_q[$];

    // model state
    bit [5:0]    edge_mask;
    logic [31:0] m_sr;
    logic [31:0] m_epc;
    bit          m_bd;
    logic [4:0]  m_exc;
    bit          m_ipreg [6];
    bit          m_pend  [6];
    bit          m_prev  [6];

    cp0_exc_ctrl #(
        .NUM_IRQ       (6),
        .IRQ_EDGE_MASK (6'b001010),
        .TEXT_BASE     (32'h0000_3000),
        .TEXT_END      (32'h0000_4180),
        .PRID_VALUE    (32'h2000_0217)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hw_int   (hw_int),
        .exc_code (exc_code),
        .exc_bd   (exc_bd),
        .md_busy  (md_busy),
        .exc_pc   (exc_pc),
        .eret     (eret),
        .mtc0_we  (mtc0_we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .irq_take (irq_take),
        .epc      (epc)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_sr  = 0;
        m_epc = 0;
        m_bd  = 0;
        m_exc = 0;
        for (int i = 0; i < 6; i++) begin
            m_ipreg[i] = 0;
            m_pend[i]  = 0;
            m_prev[i]  = 0;
        end
    endtask

    function automatic bit model_ip(int i);
        if (edge_mask[i]) return m_pend[i];
        return hw_int[i];
    endfunction

    function automatic bit model_int_req();
        bit any = 0;
        for (int i = 0; i < 6; i++)
            if (model_ip(i) && m_sr[10+i]) any = 1;
        return any && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit model_exc_req();
        return (exc_code != 0) && !m_sr[1];
    endfunction

    function automatic logic [31:0] model_read(logic [4:0] a);
        logic [31:0] c = 0;
        case (a)
            5'd12: return m_sr;
            5'd13: begin
                if (m_bd) c += 32'h8000_0000;
                for (int i = 0; i < 6; i++)
                    if (m_ipreg[i]) c += (32'd1 << (10 + i));
                c += 32'(m_exc) * 4;
                return c;
            end
            5'd14: return m_epc;
            5'd15: return 32'h2000_0217;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        bit          ti;
        bit          te;
        bit          mt;
        bit          ip_now [6];
        logic [31:0] pc;
        bit          win;
        if (reset) begin
            model_reset();
            return;
        end
        ti = model_int_req();
        te = model_exc_req();
        mt = mtc0_we && !ti && !te && !eret;
        for (int i = 0; i < 6; i++) ip_now[i] = model_ip(i);
        for (int i = 0; i < 6; i++) begin
            if (edge_mask[i]) begin
                if (hw_int[i] && !m_prev[i]) m_pend[i] = 1;
                else if (mt && wr_addr == 13 && !wr_data[10+i]) m_pend[i] = 0;
            end
            m_prev[i]  = hw_int[i];
            m_ipreg[i] = ip_now[i];
        end
        pc  = exc_pc - (exc_pc % 4);
        win = (pc >= 32'h3000) && (pc < 32'h4180);
        if (ti) begin
            m_sr  = m_sr | 32'd2;
            m_exc = 0;
            m_bd  = exc_bd;
            if (win) m_epc = exc_bd ? pc - 4 : ((exc_code == 0 && md_busy) ? pc + 4 : pc);
        end else if (te) begin
            m_sr  = m_sr | 32'd2;
            m_exc = exc_code;
            m_bd  = exc_bd;
            if (win) m_epc = exc_bd ? pc - 4 : pc;
        end else if (eret) begin
            m_sr = m_sr & ~32'd2;
        end else if (mt) begin
            if (wr_addr == 12) m_sr = wr_data;
            else if (wr_addr == 14) m_epc = wr_data - (wr_data % 4);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        reset    = 0;
        exc_code = 0;
        exc_bd   = 0;
        md_busy  = 0;
        exc_pc   = 32'h0000_3000;
        eret     = 0;
        mtc0_we  = 0;
        wr_addr  = 0;
        wr_data  = 0;
        rd_addr  = 0;
    endtask

    task automatic drive_random();
        logic [4:0] codes [4];
        logic [4:0] addrs [7];
        codes = '{5'd4, 5'd5, 5'd10, 5'd12};
        addrs = '{5'd12, 5'd12, 5'd13, 5'd13, 5'd14, 5'd15, 5'd3};
        reset = ($urandom_range(99) < 2);
        for (int i = 0; i < 6; i++)
            if ($urandom_range(9) == 0) hw_int[i] = ~hw_int[i];
        exc_code = ($urandom_range(9) < 7) ? 5'd0 : codes[$urandom_range(3)];
        exc_bd   = $urandom_range(1);
        md_busy  = $urandom_range(1);
        exc_pc   = ($urandom_range(9) == 0) ? $urandom : 32'h2FF0 + $urandom_range(32'h11A0);
        eret     = ($urandom_range(9) == 0);
        mtc0_we  = ($urandom_range(3) == 0);
        wr_addr  = addrs[$urandom_range(6)];
        wr_data  = $urandom;
        rd_addr  = $urandom_range(31);
        if (rd_addr == 5'd9 || rd_addr == 5'd11) rd_addr = 5'd13;
    endtask

    // ---------------- scoreboard ----------------
    task automatic run_cycle();
        logic [64:0] x;
        #1;
        exp_q.push_back({model_int_req() | model_exc_req(), m_epc, model_read(rd_addr)});
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            x = exp_q.pop_front();
            check("irq_take", {31'd0, irq_take}, {31'd0, x[64]});
            check("epc", epc, x[63:32]);
            check("rd_data", rd_data, x[31:0]);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic read_expect(input string tag, input logic [4:0] a, input logic [31:0] v);
        rd_addr = a;
        #1;
        check(tag, rd_data, v);
    endtask

    task automatic take_expect(input string tag, input logic v);
        #1;
        check(tag, {31'd0, irq_take}, {31'd0, v});
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        drive_idle();
        mtc0_we = 1;
        wr_addr = a;
        wr_data = d;
        run_cycle();
    endtask

    task automatic do_eret();
        drive_idle();
        eret = 1;
        run_cycle();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        edge_mask = 6'b001010;
        hw_int    = 0;
        drive_idle();
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        drive_idle();

        // reset state
        read_expect("prid", 5'd15, 32'h2000_0217);
        read_expect("sr_rst", 5'd12, 32'h0);
        read_expect("cause_rst", 5'd13, 32'h0);
        read_expect("epc_rst", 5'd14, 32'h0);
        take_expect("take_rst", 1'b0);
        run_cycle();

        // level interrupt
        mtc0(5'd12, 32'h0000_0401);
        drive_idle();
        hw_int = 6'b000001;
        exc_pc = 32'h0000_3010;
        take_expect("lvl_take", 1'b1);
        run_cycle();
        drive_idle();
        take_expect("exl_mask", 1'b0);
        read_expect("epc_lvl", 5'd14, 32'h0000_3010);
        read_expect("cause_lvl", 5'd13, 32'h0000_0400);
        read_expect("sr_exl", 5'd12, 32'h0000_0403);
        run_cycle();

        // delay slot and md_busy EPC rules
        do_eret();
        drive_idle();
        exc_bd = 1;
        exc_pc = 32'h0000_3020;
        take_expect("bd_take", 1'b1);
        run_cycle();
        drive_idle();
        read_expect("epc_bd", 5'd14, 32'h0000_301C);
        read_expect("cause_bd", 5'd13, 32'h8000_0400);
        run_cycle();
        do_eret();
        drive_idle();
        md_busy = 1;
        exc_pc  = 32'h0000_3020;
        run_cycle();
        drive_idle();
        read_expect("epc_md", 5'd14, 32'h0000_3024);
        run_cycle();
        hw_int = 0;
        do_eret();

        // synchronous exception, ignores IE/IM, window boundary
        mtc0(5'd12, 32'h0);
        drive_idle();
        exc_code = 5'd12;
        exc_pc   = 32'h0000_3040;
        take_expect("exc_take", 1'b1);
        run_cycle();
        drive_idle();
        read_expect("cause_ov", 5'd13, 32'h0000_0030);
        read_expect("epc_ov", 5'd14, 32'h0000_3040);
        eret = 1;
        run_cycle();
        drive_idle();
        exc_code = 5'd12;
        exc_pc   = 32'h0000_4180;
        run_cycle();
        drive_idle();
        read_expect("epc_window", 5'd14, 32'h0000_3040);
        eret = 1;
        run_cycle();

        // edge-latched line 1
        mtc0(5'd12, 32'h0000_0801);
        drive_idle();
        hw_int = 6'b000010;
        take_expect("edge_wait", 1'b0);
        run_cycle();
        drive_idle();
        hw_int = 0;
        take_expect("edge_take", 1'b1);
        run_cycle();
        drive_idle();
        read_expect("cause_edge", 5'd13, 32'h0000_0800);
        eret = 1;
        run_cycle();
        drive_idle();
        take_expect("edge_held", 1'b1);
        run_cycle();
        mtc0(5'd13, 32'h0);
        do_eret();
        drive_idle();
        take_expect("edge_clr", 1'b0);
        read_expect("sr_edge", 5'd12, 32'h0000_0801);
        run_cycle();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            drive_random();
            run_cycle();
        end

`ifdef CP0_TIMER_EN
        drive_idle();
        hw_int = 0;
        reset  = 1;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        mtc0_we = 1;
        wr_addr = 5'd12;
        wr_data = 32'h0000_8001;
        @(posedge clk);
        @(negedge clk);
        wr_addr = 5'd11;
        wr_data = 32'd5;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        for (int k = 1; k <= 6; k++) begin
            take_expect("tmr_wait", 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        take_expect("tmr_take", 1'b1);
        @(posedge clk);
        @(negedge clk);
        mtc0_we = 1;
        wr_addr = 5'd11;
        wr_data = 32'd100;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        eret = 1;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        take_expect("tmr_clr", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
